pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Generates PC and
//  IF/ID, ID/EX, EX/MEM, MEM/WB register load enables and bubble/flush controls from

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 15 +
 rtl/mem_resp_latch.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {RUN, LU_HOLD} hz_state_t;

    localparam int LU_BUBBLES_MAX = 3;
    localparam int SAT_W          = 64;

    // Counters of any width up to SAT_W are widened into this and cast back.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] max);
        return (value == max) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/mem_resp_latch.sv
// Catches a memory response that arrives while the pipeline is frozen by the
// other port, and replays it on the first cycle the pipeline moves again.
module mem_resp_latch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resp,
    input  logic        mem_stall,
    input  logic [31:0] rdata,
    output logic        done,
    output logic [31:0] data
);

    logic [31:0] hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            hold <= '0;
        end else if (resp && mem_stall) begin
            done <= 1'b1;
            hold <= rdata;
        end else if (!mem_stall) begin
            done <= 1'b0;
        end
    end

    assign data = done ? hold : rdata;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | normal issue; a load-use hazard inserts the first bubble
//   LU_HOLD | inserting the remaining LU_BUBBLES-1 bubbles
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic [31:0]      imem_rdata,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [31:0]      dmem_rdata,
    input  logic             IDEX_mem_read,
    input  logic [4:0]       IDEX_rd,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             IFID_use_rs1,
    input  logic             IFID_use_rs2,
    input  logic             EX_br_taken,
    output logic             pc_load,
    output logic             IFID_load,
    output logic             IDEX_load,
    output logic             EXMEM_load,
    output logic             MEMWB_load,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic [31:0]      fetch_instr,
    output logic [31:0]      load_data,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    if (LU_BUBBLES < 1 || LU_BUBBLES > LU_BUBBLES_MAX) begin : g_bad_lu
        $error("LU_BUBBLES out of range");
    end
    if (CNT_W < 1 || CNT_W > SAT_W) begin : g_bad_cnt
        $error("CNT_W out of range");
    end

    localparam logic [1:0]       BUB_RELOAD = 2'(LU_BUBBLES - 1);
    localparam logic [SAT_W-1:0] CNT_MAX    = SAT_W'({CNT_W{1'b1}});

    hz_state_t  state, state_nxt;
    logic [1:0] bubble_cnt, bubble_cnt_nxt;
    logic       i_done, d_done;
    logic       i_ok, d_ok, mem_stall;
    logic       lu_haz, redirect, bubble_ins;

    mem_resp_latch u_i_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .resp      (imem_resp),
        .mem_stall (mem_stall),
        .rdata     (imem_rdata),
        .done      (i_done),
        .data      (fetch_instr)
    );

    mem_resp_latch u_d_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .resp      (dmem_resp),
        .mem_stall (mem_stall),
        .rdata     (dmem_rdata),
        .done      (d_done),
        .data      (load_data)
    );

    assign i_ok      = ~imem_read | imem_resp | i_done;
    assign d_ok      = ~dmem_req  | dmem_resp | d_done;
    assign mem_stall = ~(i_ok & d_ok);

    assign lu_haz = IDEX_mem_read && (IDEX_rd != 5'd0) &&
                    ((IFID_use_rs1 && (IFID_rs1 == IDEX_rd)) ||
                     (IFID_use_rs2 && (IFID_rs2 == IDEX_rd)));

    // A redirect seen during a stall is simply re-presented by EX next cycle.
    assign redirect   = ~mem_stall & EX_br_taken;
    assign bubble_ins = ~mem_stall & ~EX_br_taken & ((state == LU_HOLD) | lu_haz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            bubble_cnt <= '0;
        end else begin
            state      <= state_nxt;
            bubble_cnt <= bubble_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bubble_cnt_nxt = bubble_cnt;
        if (!mem_stall) begin
            if (EX_br_taken) begin
                state_nxt      = RUN;
                bubble_cnt_nxt = '0;
            end else if (state == RUN) begin
                if (lu_haz && (LU_BUBBLES > 1)) begin
                    state_nxt      = LU_HOLD;
                    bubble_cnt_nxt = BUB_RELOAD;
                end
            end else begin
                bubble_cnt_nxt = bubble_cnt - 2'd1;
                if (bubble_cnt == 2'd1) begin
                    state_nxt = RUN;
                end
            end
        end
    end

    always_comb begin
        pc_load    = 1'b0;
        IFID_load  = 1'b0;
        IDEX_load  = 1'b0;
        EXMEM_load = 1'b0;
        MEMWB_load = 1'b0;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        if (rst_n && !mem_stall) begin
            IDEX_load  = 1'b1;
            EXMEM_load = 1'b1;
            MEMWB_load = 1'b1;
            if (EX_br_taken) begin
                pc_load    = 1'b1;
                IFID_load  = 1'b1;
                IFID_flush = 1'b1;
                IDEX_flush = 1'b1;
            end else if ((state == LU_HOLD) || lu_haz) begin
                IDEX_flush = 1'b1;
            end else begin
                pc_load    = 1'b1;
                IFID_load  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (mem_stall) begin
                stall_cycles <= CNT_W'(sat_inc(SAT_W'(stall_cycles), CNT_MAX));
            end
            if (bubble_ins) begin
                bubble_count <= CNT_W'(sat_inc(SAT_W'(bubble_count), CNT_MAX));
            end
            if (redirect) begin
                flush_count <= CNT_W'(sat_inc(SAT_W'(flush_count), CNT_MAX));
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: one instance with single bubbles and wide counters, one with
// three bubbles and 3-bit counters to reach saturation quickly.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_read, imem_resp, dmem_req, dmem_resp;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        IDEX_mem_read, IFID_use_rs1, IFID_use_rs2, EX_br_taken;
    logic [4:0]  IDEX_rd, IFID_rs1, IFID_rs2;

    logic        pc1, ifid1, idex1, exmem1, memwb1, iff1, idf1;
    logic [31:0] fetch1, load1, stall1, bub1, flush1;
    logic        pc3, ifid3, idex3, exmem3, memwb3, iff3, idf3;
    logic [31:0] fetch3, load3;
    logic [2:0]  stall3, bub3, flush3;
    logic [6:0]  ctl1, ctl3;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] NORM = 7'b1111100;
    localparam logic [6:0] BUB  = 7'b0011101;
    localparam logic [6:0] RDR  = 7'b1111111;

    always #5 clk = ~clk;

    assign ctl1 = {pc1, ifid1, idex1, exmem1, memwb1, iff1, idf1};
    assign ctl3 = {pc3, ifid3, idex3, exmem3, memwb3, iff3, idf3};

    pipeline_hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .imem_read(imem_read), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .IDEX_mem_read(IDEX_mem_read), .IDEX_rd(IDEX_rd),
        .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_use_rs1(IFID_use_rs1), .IFID_use_rs2(IFID_use_rs2),
        .EX_br_taken(EX_br_taken),
        .pc_load(pc1), .IFID_load(ifid1), .IDEX_load(idex1), .EXMEM_load(exmem1),
        .MEMWB_load(memwb1), .IFID_flush(iff1), .IDEX_flush(idf1),
        .fetch_instr(fetch1), .load_data(load1),
        .stall_cycles(stall1), .bubble_count(bub1), .flush_count(flush1)
    );

    pipeline_hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .imem_read(imem_read), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .IDEX_mem_read(IDEX_mem_read), .IDEX_rd(IDEX_rd),
        .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_use_rs1(IFID_use_rs1), .IFID_use_rs2(IFID_use_rs2),
        .EX_br_taken(EX_br_taken),
        .pc_load(pc3), .IFID_load(ifid3), .IDEX_load(idex3), .EXMEM_load(exmem3),
        .MEMWB_load(memwb3), .IFID_flush(iff3), .IDEX_flush(idf3),
        .fetch_instr(fetch3), .load_data(load3),
        .stall_cycles(stall3), .bubble_count(bub3), .flush_count(flush3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imem_read     = 1'b0;
        imem_resp     = 1'b0;
        imem_rdata    = '0;
        dmem_req      = 1'b0;
        dmem_resp     = 1'b0;
        dmem_rdata    = '0;
        IDEX_mem_read = 1'b0;
        IDEX_rd       = '0;
        IFID_rs1      = '0;
        IFID_rs2      = '0;
        IFID_use_rs1  = 1'b0;
        IFID_use_rs2  = 1'b0;
        EX_br_taken   = 1'b0;
    endtask

    // ld x5 in ID/EX; add x6,x5,x1 in IF/ID
    task automatic load_use();
        IDEX_mem_read = 1'b1;
        IDEX_rd       = 5'd5;
        IFID_rs1      = 5'd5;
        IFID_rs2      = 5'd1;
        IFID_use_rs1  = 1'b1;
        IFID_use_rs2  = 1'b1;
    endtask

    initial begin
        // reset with hazard and redirect driven: controls must stay low
        rst_n = 1'b0;
        idle();
        load_use();
        EX_br_taken = 1'b1;
        #2;
        check("rst_ctl1", 32'(ctl1), 32'(NONE));
        check("rst_ctl3", 32'(ctl3), 32'(NONE));
        check("rst_stall", stall1, 32'd0);
        check("rst_bubble", bub1, 32'd0);
        check("rst_flush", flush1, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        check("run_ctl1", 32'(ctl1), 32'(NORM));
        check("run_ctl3", 32'(ctl3), 32'(NORM));
        tick();

        // load-use, then a 2-cycle data stall while dut3 is still bubbling
        load_use();
        #1;
        check("lu_ctl1", 32'(ctl1), 32'(BUB));
        check("lu_ctl3", 32'(ctl3), 32'(BUB));
        tick();
        check("lu_bub1", bub1, 32'd1);
        check("lu_bub3", 32'(bub3), 32'd1);
        idle();
        dmem_req = 1'b1;
        #1;
        check("dst_ctl1", 32'(ctl1), 32'(NONE));
        check("dst_ctl3", 32'(ctl3), 32'(NONE));
        tick();
        tick();
        check("dst_stall1", stall1, 32'd2);
        check("dst_stall3", 32'(stall3), 32'd2);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        check("dresp_ctl1", 32'(ctl1), 32'(NORM));
        check("dresp_ctl3", 32'(ctl3), 32'(BUB));
        check("dresp_load", load1, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        check("hold2_ctl3", 32'(ctl3), 32'(BUB));
        check("hold2_ctl1", 32'(ctl1), 32'(NORM));
        tick();
        check("hold_bub3", 32'(bub3), 32'd3);
        check("hold_bub1", bub1, 32'd1);
        #1;
        check("hold_done3", 32'(ctl3), 32'(NORM));
        tick();

        // hazard qualifiers: rd=x0, unused rs2, used rs2
        IDEX_mem_read = 1'b1;
        IDEX_rd       = 5'd0;
        IFID_rs1      = 5'd0;
        IFID_use_rs1  = 1'b1;
        #1;
        check("x0_ctl1", 32'(ctl1), 32'(NORM));
        tick();
        IDEX_rd      = 5'd5;
        IFID_rs1     = 5'd3;
        IFID_rs2     = 5'd5;
        IFID_use_rs2 = 1'b0;
        #1;
        check("nors2_ctl1", 32'(ctl1), 32'(NORM));
        tick();
        check("nors2_bub1", bub1, 32'd1);
        IFID_use_rs2 = 1'b1;
        #1;
        check("rs2_ctl1", 32'(ctl1), 32'(BUB));
        tick();
        check("rs2_bub1", bub1, 32'd2);

        // async reset while dut3 is in LU_HOLD
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_ctl3", 32'(ctl3), 32'(NONE));
        check("arst_ctl1", 32'(ctl1), 32'(NONE));
        check("arst_bub3", 32'(bub3), 32'd0);
        check("arst_stall1", stall1, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("arel_ctl3", 32'(ctl3), 32'(NORM));
        tick();

        // fetch returns early, load returns later: fetch word must be held
        imem_read = 1'b1;
        dmem_req  = 1'b1;
        #1;
        check("split_c1", 32'(ctl1), 32'(NONE));
        tick();
        imem_resp  = 1'b1;
        imem_rdata = 32'h00A00093;
        #1;
        check("split_pass", fetch1, 32'h00A00093);
        tick();
        imem_resp  = 1'b0;
        imem_rdata = 32'hFFFFFFFF;
        #1;
        check("split_held", fetch1, 32'h00A00093);
        check("split_c3", 32'(ctl1), 32'(NONE));
        tick();
        tick();
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h12345678;
        #1;
        check("split_go", 32'(ctl1), 32'(NORM));
        check("split_fetch", fetch1, 32'h00A00093);
        check("split_load", load1, 32'h12345678);
        tick();
        check("split_stall1", stall1, 32'd4);
        check("split_stall3", 32'(stall3), 32'd4);
        dmem_req   = 1'b0;
        dmem_resp  = 1'b0;
        imem_resp  = 1'b1;
        imem_rdata = 32'h11111111;
        #1;
        check("split_clear", fetch1, 32'h11111111);
        check("split_next", 32'(ctl1), 32'(NORM));
        tick();
        check("split_stall_end", stall1, 32'd4);

        // redirect beats load-use and aborts LU_HOLD
        idle();
        load_use();
        EX_br_taken = 1'b1;
        #1;
        check("rdr_lu_ctl1", 32'(ctl1), 32'(RDR));
        check("rdr_lu_ctl3", 32'(ctl3), 32'(RDR));
        tick();
        check("rdr_flush1", flush1, 32'd1);
        check("rdr_bub1", bub1, 32'd0);
        check("rdr_bub3", 32'(bub3), 32'd0);
        EX_br_taken = 1'b0;
        #1;
        check("rdr_then_lu", 32'(ctl1), 32'(BUB));
        tick();
        check("rdr_then_bub1", bub1, 32'd1);
        idle();
        EX_br_taken = 1'b1;
        #1;
        check("rdr_abort_ctl3", 32'(ctl3), 32'(RDR));
        tick();
        check("rdr_flush3", 32'(flush3), 32'd2);
        EX_br_taken = 1'b0;
        #1;
        check("rdr_abort_run3", 32'(ctl3), 32'(NORM));
        tick();

        // redirect during a stall waits for the stall to end
        EX_br_taken = 1'b1;
        dmem_req    = 1'b1;
        #1;
        check("rdr_stall_ctl1", 32'(ctl1), 32'(NONE));
        tick();
        check("rdr_stall_flush", flush1, 32'd2);
        dmem_resp = 1'b1;
        #1;
        check("rdr_late_ctl1", 32'(ctl1), 32'(RDR));
        tick();
        check("rdr_late_flush", flush1, 32'd3);
        check("rdr_late_stall", stall1, 32'd5);

        // saturation of the 3-bit stall counter
        idle();
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("sat_stall1", stall1, 32'd9);
        check("sat_stall3", 32'(stall3), 32'd7);
        dmem_resp = 1'b1;
        tick();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
